bus_mem_arb: RTL

Multi-port, parametrised successor to the tiny-cpu bus memory: a word-organised RAM with byte lanes, shared by NUM_PORTS requesters. Each requester uses the toggle handshake, where a request is pending while run≠done. A round-robin arbiter serialises the requests, and a configurable wait-state counter models slow memory. It sits on the CPU bus in place of the single-port memory, so the CPU fetch/data path and a future DMA or display reader can share one RAM.

---
 rtl/bus_mem_arb_if.sv | 26 ++
 rtl/bus_mem_arb.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/bus_mem_arb_if.sv
// Bus bundle for bus_mem_arb: per-port toggle handshake, command, address and data lanes.
// Each per-port field is packed port-major (port i occupies slice i of every vector).
interface bus_mem_arb_if #(
   parameter int NUM_PORTS = 2,
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 16
);
   logic [NUM_PORTS-1:0]        run;
   logic [2*NUM_PORTS-1:0]      cmd;
   logic [ADDR_W*NUM_PORTS-1:0] addr;
   logic [DATA_W*NUM_PORTS-1:0] wr_data;
   logic [DATA_W*NUM_PORTS-1:0] rd_data;
   logic [NUM_PORTS-1:0]        done;
   logic                        busy;
   logic [NUM_PORTS-1:0]        err;

   modport master (
      output run, cmd, addr, wr_data,
      input  rd_data, done, busy, err
   );

   modport slave (
      input  run, cmd, addr, wr_data,
      output rd_data, done, busy, err
   );
endinterface

// File: rtl/bus_mem_arb.sv
// Multi-port byte-lane RAM with round-robin arbitration over toggle handshakes and wait states.
// Optional BUS_MEM_ERR_EN: flag out-of-range word indices instead of aliasing them.
module bus_mem_arb #(
   parameter int NUM_PORTS   = 2,
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 16,
   parameter int DEPTH       = 32768,
   parameter int WAIT_STATES = 0
) (
   input logic          clk,
   input logic          reset_n,
   bus_mem_arb_if.slave bus
);
   localparam int NB  = DATA_W / 8;
   localparam int SH  = $clog2(NB);
   localparam int BIW = (NB > 1) ? SH : 1;
   localparam int MW  = $clog2(DEPTH);
   localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WAIT   = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [3:0] WS_INIT   = 4'(WAIT_STATES);

   logic [DATA_W-1:0] mem [DEPTH];

   logic [1:0]                  state_r;
   logic [3:0]                  wcnt_r;
   logic [PW-1:0]               rr_r;
   logic [PW-1:0]               g_r;
   logic [1:0]                  cmd_r;
   logic [ADDR_W-1:0]           addr_r;
   logic [DATA_W-1:0]           wd_r;
   logic [NUM_PORTS-1:0]        done_r;
   logic [DATA_W*NUM_PORTS-1:0] rd_r;
   logic [NUM_PORTS-1:0]        err_r;
   logic                        busy_r;

   logic [NUM_PORTS-1:0] pend_s;
   logic [NUM_PORTS-1:0] rot_s;
   logic                 found_s;
   logic [PW-1:0]        gsel_s;
   logic [ADDR_W-1:0]    widx_s;
   logic [MW-1:0]        midx_s;
   logic [BIW-1:0]       bidx_s;
   logic [DATA_W-1:0]    rword_s;
   logic [7:0]           rbyte_s;
   logic [DATA_W-1:0]    rval_s;
   logic                 oor_s;
   logic                 we_s;

   // Round-robin pick: rotate pending so rr_r lands at bit 0, take the lowest set bit.
   always_comb begin
      pend_s  = bus.run ^ done_r;
      rot_s   = NUM_PORTS'({pend_s, pend_s} >> rr_r);
      found_s = 1'b0;
      gsel_s  = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (!found_s && rot_s[k]) begin
            found_s = 1'b1;
            gsel_s  = PW'((int'(rr_r) + k) % NUM_PORTS);
         end else begin
            found_s = found_s;
         end
      end
   end

   // Address decode and read-data formatting for the latched transaction.
   always_comb begin
      widx_s  = addr_r >> SH;
      midx_s  = MW'(widx_s);
      bidx_s  = (NB > 1) ? addr_r[BIW-1:0] : '0;
`ifdef BUS_MEM_ERR_EN
      oor_s   = ((widx_s >> MW) != '0);
`else
      oor_s   = 1'b0;
`endif
      rword_s = mem[midx_s];
      rbyte_s = 8'(rword_s >> {bidx_s, 3'b000});
      if (oor_s) begin
         rval_s = '0;
      end else if (cmd_r[1]) begin
         rval_s = DATA_W'(rbyte_s);
      end else begin
         rval_s = rword_s;
      end
      we_s = (state_r == ST_ACCESS) && cmd_r[0] && !oor_s;
   end

   // Memory array write port; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (we_s) begin
         for (int l = 0; l < NB; l++) begin
            if (!cmd_r[1] || (bidx_s == BIW'(l))) begin
               mem[midx_s][8*l +: 8] <= cmd_r[1] ? wd_r[7:0] : wd_r[8*l +: 8];
            end
         end
      end
   end

   // Transaction sequencer: grant, wait-state countdown, access and completion toggle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
         wcnt_r  <= 4'd0;
         rr_r    <= '0;
         g_r     <= '0;
         cmd_r   <= 2'b00;
         addr_r  <= '0;
         wd_r    <= '0;
         done_r  <= '0;
         rd_r    <= '0;
         err_r   <= '0;
         busy_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (found_s) begin
                  g_r    <= gsel_s;
                  cmd_r  <= bus.cmd[2*int'(gsel_s) +: 2];
                  addr_r <= bus.addr[ADDR_W*int'(gsel_s) +: ADDR_W];
                  wd_r   <= bus.wr_data[DATA_W*int'(gsel_s) +: DATA_W];
                  wcnt_r <= WS_INIT;
                  busy_r <= 1'b1;
                  state_r <= (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
               end
            end
            ST_WAIT: begin
               wcnt_r <= wcnt_r - 4'd1;
               busy_r <= 1'b1;
               if (wcnt_r == 4'd1) begin
                  state_r <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               done_r[g_r] <= ~done_r[g_r];
               err_r[g_r]  <= oor_s;
               if (!cmd_r[0]) begin
                  rd_r[DATA_W*int'(g_r) +: DATA_W] <= rval_s;
               end
               rr_r    <= (g_r == PW'(NUM_PORTS - 1)) ? '0 : g_r + PW'(1);
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.done    = done_r;
   assign bus.rd_data = rd_r;
   assign bus.err     = err_r;
   assign bus.busy    = busy_r;
endmodule
